sign_extension_pipe: RTL

Parametrised, registered immediate-extension unit with four extension modes and a 2-entry elastic buffer on a valid/ready interface. It replaces a purely combinational sign extender in the datapath. It sits between instruction decode and the execute-stage operand muxes, so decode can stall or run ahead of execute without losing immediates.

---
 rtl/sign_extension_pipe.sv | 95 +++++++++
 1 files changed

// File: rtl/sign_extension_pipe.sv
// sign_extension_pipe: registered immediate extender (sign/zero/upper/branch)
// behind a 2-entry valid/ready elastic buffer.
module sign_extension_pipe #(
   parameter int NB_DATA_IN       = 16,
   parameter int NB_EXTENDED_DATA = 32,
   parameter int NB_DIFF          = NB_EXTENDED_DATA - NB_DATA_IN
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_flush,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [NB_DATA_IN-1:0]       i_data,
   input  logic [1:0]                  i_mode,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [NB_EXTENDED_DATA-1:0] o_extended_data,
   output logic [1:0]                  o_mode
);

   localparam logic [1:0] MODE_SIGN   = 2'd0;
   localparam logic [1:0] MODE_ZERO   = 2'd1;
   localparam logic [1:0] MODE_UPPER  = 2'd2;
   localparam logic [1:0] MODE_BRANCH = 2'd3;

   generate
      if ((NB_EXTENDED_DATA < NB_DATA_IN + 2) ||
          (NB_DIFF != NB_EXTENDED_DATA - NB_DATA_IN)) begin : g_bad_params
         $error("sign_extension_pipe: bad width parameters");
      end
   endgenerate

   logic [NB_EXTENDED_DATA-1:0] sign_ext;
   logic [NB_EXTENDED_DATA-1:0] ext_data;

   logic [NB_EXTENDED_DATA-1:0] data_q [2];
   logic [1:0]                  mode_q [2];
   logic                        rd_ptr;
   logic                        wr_ptr;
   logic [1:0]                  count;
   logic                        push;
   logic                        pop;

   assign sign_ext = {{NB_DIFF{i_data[NB_DATA_IN-1]}}, i_data};

   // Two guard bits from the width constraint keep BRANCH lossless.
   always_comb begin
      ext_data = sign_ext;
      unique case (i_mode)
         MODE_SIGN:   ext_data = sign_ext;
         MODE_ZERO:   ext_data = {{NB_DIFF{1'b0}}, i_data};
         MODE_UPPER:  ext_data = {i_data, {NB_DIFF{1'b0}}};
         MODE_BRANCH: ext_data = {sign_ext[NB_EXTENDED_DATA-3:0], 2'b00};
      endcase
   end

   assign o_ready = (count != 2'd2);
   assign o_valid = (count != 2'd0);
   assign push    = i_valid & o_ready;
   assign pop     = o_valid & i_ready;

   assign o_extended_data = data_q[rd_ptr];
   assign o_mode          = mode_q[rd_ptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            mode_q[i] <= '0;
         end
      end else if (i_flush) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= ext_data;
            mode_q[wr_ptr] <= i_mode;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
